// File: rtl/match_len_accum_if.sv
// ============================================================================
// match_len_accum_if : compare-beat input and result output bundle for
//                      match_len_accum.
// Rev 1.0
// ============================================================================
`default_nettype none

interface match_len_accum_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_start;
  logic [5:0]  in_cnt;
  logic [14:0] in_dist;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_len;
  logic [14:0] out_dist;
  logic        out_is_match;
  logic        proto_err;

  modport master (
    output in_valid, in_start, in_cnt, in_dist, out_ready,
    input  in_ready, out_valid, out_len, out_dist, out_is_match, proto_err
  );

  modport slave (
    input  in_valid, in_start, in_cnt, in_dist, out_ready,
    output in_ready, out_valid, out_len, out_dist, out_is_match, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/match_len_accum.sv
// ============================================================================
// match_len_accum : sums per-beat compare counts into one Deflate match length
//                   (saturating at MAX_LEN). Optional MLA_STATS_EN adds
//                   result counters stat_matches / stat_caps.
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_9bits (
  input  wire logic [8:0] i_a,
  input  wire logic [8:0] i_b,
  input  wire logic       i_ci,
  output logic      [8:0] o_s,
  output logic            o_co
);
  assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {9'd0, i_ci};
endmodule

module match_len_accum #(
  parameter int VEC     = 16,
  parameter int MAX_LEN = 258,
  parameter int MIN_LEN = 3
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  match_len_accum_if.slave     bus
`ifdef MLA_STATS_EN
  ,
  output logic [31:0]          stat_matches,
  output logic [31:0]          stat_caps
`endif
);

  localparam logic [5:0] c_vec     = 6'(VEC);
  localparam logic [8:0] c_max_len = 9'(MAX_LEN);
  localparam logic [8:0] c_min_len = 9'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [8:0]  r_len;
  logic [14:0] r_dist;
  logic [8:0]  r_out_len;
  logic [14:0] r_out_dist;
  logic        r_out_is_match;
  logic        r_proto_err;

  state_t      w_state_nxt;
  logic [8:0]  w_len_nxt;
  logic [14:0] w_dist_nxt;
  logic        w_load;
  logic        w_err_nxt;

  logic [5:0]  w_cnt;
  logic [8:0]  w_cnt9;
  logic [8:0]  w_sum;
  logic        w_co;
  logic [8:0]  w_acc_len;
  logic [8:0]  w_start_len;
  logic        w_short;
  logic        w_fire;

  // Out-of-range counts are treated as a full-width match.
  assign w_cnt   = (bus.in_cnt > c_vec) ? c_vec : bus.in_cnt;
  assign w_cnt9  = {3'b000, w_cnt};
  assign w_short = (w_cnt < c_vec);
  assign w_fire  = bus.in_valid & bus.in_ready;

  adder_9bits u_add (
    .i_a  (r_len),
    .i_b  (w_cnt9),
    .i_ci (1'b0),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  assign w_acc_len   = (w_co || (w_sum >= c_max_len)) ? c_max_len : w_sum;
  assign w_start_len = (w_cnt9 >= c_max_len) ? c_max_len : w_cnt9;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_dist_nxt  = r_dist;
    w_load      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_fire) begin
          if (bus.in_start) begin
            // A start while accumulating abandons the partial match.
            w_err_nxt  = (r_state == S_ACCUM);
            w_len_nxt  = w_start_len;
            w_dist_nxt = bus.in_dist;
            w_load     = w_short || (w_start_len == c_max_len);
            w_state_nxt = w_load ? S_EMIT : S_ACCUM;
          end else if (r_state == S_ACCUM) begin
            w_len_nxt   = w_acc_len;
            w_load      = w_short || (w_acc_len == c_max_len);
            w_state_nxt = w_load ? S_EMIT : S_ACCUM;
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
          w_len_nxt   = 9'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_len          <= 9'd0;
      r_dist         <= 15'd0;
      r_out_len      <= 9'd0;
      r_out_dist     <= 15'd0;
      r_out_is_match <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_dist      <= w_dist_nxt;
      r_proto_err <= w_err_nxt;
      if (w_load) begin
        r_out_len      <= w_len_nxt;
        r_out_dist     <= w_dist_nxt;
        r_out_is_match <= (w_len_nxt >= c_min_len);
      end
    end
  end

  assign bus.in_ready     = (r_state != S_EMIT);
  assign bus.out_valid    = (r_state == S_EMIT);
  assign bus.out_len      = r_out_len;
  assign bus.out_dist     = r_out_dist;
  assign bus.out_is_match = r_out_is_match;
  assign bus.proto_err    = r_proto_err;

`ifdef MLA_STATS_EN
  logic [31:0] r_stat_matches;
  logic [31:0] r_stat_caps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_matches <= 32'd0;
      r_stat_caps    <= 32'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (r_out_is_match)
        r_stat_matches <= r_stat_matches + 32'd1;
      if (r_out_len == c_max_len)
        r_stat_caps <= r_stat_caps + 32'd1;
    end
  end

  assign stat_matches = r_stat_matches;
  assign stat_caps    = r_stat_caps;
`endif

endmodule

`default_nettype wire
